// File: rtl/mic_frame_scheduler_if.sv
// mic_frame_scheduler_if: mic capture, config and codec-stream signals of the frame scheduler.
interface mic_frame_scheduler_if #(
    parameter int NUM_MICS = 4
);
    logic [NUM_MICS-1:0]    MIC_VALID;
    logic [32*NUM_MICS-1:0] MIC_DATA;
    logic [NUM_MICS-1:0]    MIC_ACK;
    logic                   CFG_WRITE;
    logic [15:0]            CFG_WRITEDATA;
    logic [15:0]            CFG_READDATA;
    logic [31:0]            codec_stream;
    logic                   frame_strobe;
    logic                   interrupt;

    modport master (
        output MIC_VALID, MIC_DATA, CFG_WRITE, CFG_WRITEDATA,
        input  MIC_ACK, CFG_READDATA, codec_stream, frame_strobe, interrupt
    );

    modport slave (
        input  MIC_VALID, MIC_DATA, CFG_WRITE, CFG_WRITEDATA,
        output MIC_ACK, CFG_READDATA, codec_stream, frame_strobe, interrupt
    );
endinterface

// File: rtl/mic_frame_scheduler.sv
// mic_frame_scheduler: once per ADC frame selects or mixes mic samples into the codec playback word.
module mic_frame_scheduler #(
    parameter int NUM_MICS = 4,
    parameter int IDX_W    = $clog2(NUM_MICS)
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 AUD_ADCLRCK,
    mic_frame_scheduler_if.slave bus
);
    typedef enum logic [1:0] {WAIT_EDGE, SELECT, ACCUM, PUBLISH} state_t;

    state_t              state;
    logic [2:0]          sync, fill;
    logic [1:0]          pend_mode, act_mode;
    logic [IDX_W-1:0]    pend_idx, act_idx, ch;
    logic [7:0]          pend_dwell, act_dwell, rr_cnt;
    logic                pend_new, sticky, any_v, strobe;
    logic signed [17:0]  acc_l, acc_r, sum_l, sum_r, mix_l, mix_r;
    logic [NUM_MICS-1:0] ack_acc, ack_now, ack, sel_hot;
    logic [31:0]         word, sel_data, ch_data;
    logic                sel_v, ch_v, lrck_rise, set_sticky, clr_sticky;
    logic [15:0]         rd;
    logic                unused_cfg;

    // fill gates the edge detector so a level-high LRCK right after reset is not mistaken for a rise
    always_comb begin
        lrck_rise  = sync[1] & ~sync[2] & fill[2];
        sel_data   = bus.MIC_DATA[{act_idx, 5'd0} +: 32];
        ch_data    = bus.MIC_DATA[{ch, 5'd0} +: 32];
        sel_v      = bus.MIC_VALID[act_idx];
        ch_v       = bus.MIC_VALID[ch];
        sel_hot    = {{(NUM_MICS-1){1'b0}}, 1'b1} << act_idx;
        sum_l      = acc_l + (ch_v ? {{2{ch_data[31]}}, ch_data[31:16]} : 18'd0);
        sum_r      = acc_r + (ch_v ? {{2{ch_data[15]}}, ch_data[15:0]} : 18'd0);
        mix_l      = sum_l >>> IDX_W;
        mix_r      = sum_r >>> IDX_W;
        ack_now    = ack_acc | ({{(NUM_MICS-1){1'b0}}, ch_v} << ch);
        set_sticky = (lrck_rise && state != WAIT_EDGE)
                  || (state == SELECT && !act_mode[1] && !sel_v)
                  || (state == ACCUM && &ch && !(any_v || ch_v));
        clr_sticky = bus.CFG_WRITE && bus.CFG_WRITEDATA[4];
        rd         = '0;
        rd[1:0]    = act_mode;
        rd[2 +: IDX_W] = act_idx;
        rd[4]      = sticky;
        rd[15:8]   = act_dwell;
        unused_cfg = ^bus.CFG_WRITEDATA[7:5];
    end

    assign bus.MIC_ACK      = ack;
    assign bus.codec_stream = word;
    assign bus.frame_strobe = strobe;
    assign bus.interrupt    = sticky;
    assign bus.CFG_READDATA = rd;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= WAIT_EDGE;
            sync       <= '0;
            fill       <= '0;
            pend_mode  <= '0;
            pend_idx   <= '0;
            pend_dwell <= '0;
            pend_new   <= 1'b0;
            act_mode   <= '0;
            act_idx    <= '0;
            act_dwell  <= '0;
            rr_cnt     <= '0;
            ch         <= '0;
            acc_l      <= '0;
            acc_r      <= '0;
            any_v      <= 1'b0;
            ack_acc    <= '0;
            ack        <= '0;
            word       <= '0;
            strobe     <= 1'b0;
            sticky     <= 1'b0;
        end else begin
            sync   <= {sync[1:0], AUD_ADCLRCK};
            fill   <= {fill[1:0], 1'b1};
            strobe <= 1'b0;
            ack    <= '0;
            sticky <= set_sticky || (sticky && !clr_sticky);
            case (state)
                WAIT_EDGE: if (lrck_rise) begin
                    state <= SELECT;
                    if (pend_new) begin
                        act_mode  <= pend_mode;
                        act_idx   <= pend_idx;
                        act_dwell <= pend_dwell;
                        rr_cnt    <= '0;
                        pend_new  <= 1'b0;
                    end
                end
                SELECT: if (act_mode == 2'd2) begin
                    state   <= ACCUM;
                    ch      <= '0;
                    acc_l   <= '0;
                    acc_r   <= '0;
                    any_v   <= 1'b0;
                    ack_acc <= '0;
                end else begin
                    state  <= PUBLISH;
                    strobe <= 1'b1;
                    if (act_mode == 2'd3) word <= '0;
                    else if (sel_v) begin
                        word <= sel_data;
                        ack  <= sel_hot;
                    end
                    if (act_mode == 2'd1) begin
                        rr_cnt <= (rr_cnt == act_dwell) ? 8'd0 : rr_cnt + 8'd1;
                        if (rr_cnt == act_dwell) act_idx <= act_idx + 1'b1;
                    end
                end
                ACCUM: begin
                    acc_l   <= sum_l;
                    acc_r   <= sum_r;
                    any_v   <= any_v || ch_v;
                    ack_acc <= ack_now;
                    ch      <= ch + 1'b1;
                    if (&ch) begin
                        state  <= PUBLISH;
                        strobe <= 1'b1;
                        word   <= {mix_l[15:0], mix_r[15:0]};
                        ack    <= ack_now;
                    end
                end
                default: state <= WAIT_EDGE;
            endcase
            if (bus.CFG_WRITE) begin
                pend_mode  <= bus.CFG_WRITEDATA[1:0];
                pend_idx   <= bus.CFG_WRITEDATA[2 +: IDX_W];
                pend_dwell <= bus.CFG_WRITEDATA[15:8];
                pend_new   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mic_frame_scheduler.sv
// tb_mic_frame_scheduler: directed frames with a scoreboard checked by an independent monitor.
module tb_mic_frame_scheduler;
    typedef struct {
        logic [31:0] w;
        logic [3:0]  a;
        int          c;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, lrck = 1'b0;
    int          cyc = 0, tests = 0, fails = 0, strobes = 0, s0 = 0;
    exp_t        sb[$];
    logic [31:0] mdat[4];

    mic_frame_scheduler_if #(.NUM_MICS(4)) bus();

    mic_frame_scheduler #(.NUM_MICS(4)) dut (
        .CLK(clk),
        .RESET_N(rst_n),
        .AUD_ADCLRCK(lrck),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (bus.frame_strobe) begin
                strobes++;
                chk("strobe_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("codec_stream", bus.codec_stream, e.w);
                    chk("mic_ack", 32'(bus.MIC_ACK), 32'(e.a));
                    chk("strobe_cycle", 32'(cyc), 32'(e.c));
                end
            end else if (bus.MIC_ACK != 4'd0) chk("stray_ack", 32'(bus.MIC_ACK), 32'd0);
        end
    end

    task automatic drive(input logic [3:0] v);
        bus.MIC_DATA  = {mdat[3], mdat[2], mdat[1], mdat[0]};
        bus.MIC_VALID = v;
    endtask

    task automatic cfg(input logic [15:0] d);
        @(negedge clk);
        bus.CFG_WRITE     = 1'b1;
        bus.CFG_WRITEDATA = d;
        @(negedge clk);
        bus.CFG_WRITE     = 1'b0;
    endtask

    task automatic frame(input logic [31:0] w, input logic [3:0] a, input int lat,
                         input bit mid, input logic [15:0] md);
        @(negedge clk);
        lrck = 1'b1;
        sb.push_back('{w, a, cyc + lat});
        repeat (3) @(negedge clk);
        if (mid) begin
            bus.CFG_WRITE     = 1'b1;
            bus.CFG_WRITEDATA = md;
            @(negedge clk);
            bus.CFG_WRITE     = 1'b0;
        end else @(negedge clk);
        repeat (6) @(negedge clk);
        lrck = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        bus.MIC_VALID     = '0;
        bus.MIC_DATA      = '0;
        bus.CFG_WRITE     = 1'b0;
        bus.CFG_WRITEDATA = '0;
        repeat (3) @(negedge clk);
        chk("rst_codec", bus.codec_stream, 32'h0);
        chk("rst_strobe", 32'(bus.frame_strobe), 32'h0);
        chk("rst_ack", 32'(bus.MIC_ACK), 32'h0);
        chk("rst_irq", 32'(bus.interrupt), 32'h0);
        chk("rst_rd", 32'(bus.CFG_READDATA), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        mdat = '{32'h0, 32'h0, 32'h1234ABCD, 32'h0};
        drive(4'b0100);
        cfg(16'h0008);
        chk("rd_before_edge", 32'(bus.CFG_READDATA), 32'h0000);
        frame(32'h1234ABCD, 4'b0100, 4, 1'b0, 16'h0);
        chk("rd_fixed", 32'(bus.CFG_READDATA), 32'h0008);

        mdat = '{32'h1000_2000, 32'h1001_2001, 32'h1002_2002, 32'h1003_2003};
        drive(4'b1111);
        cfg(16'h0101);
        for (int k = 0; k < 10; k++)
            frame(mdat[(k / 2) % 4], 4'(1 << ((k / 2) % 4)), 4, 1'b0, 16'h0);
        chk("rd_rr", 32'(bus.CFG_READDATA), 32'h0105);

        cfg(16'h0002);
        mdat = '{32'h7FFF_FFFF, 32'h7FFF_0000, 32'h8000_0000, 32'h0001_0000};
        drive(4'b1111);
        frame(32'h1FFF_FFFF, 4'b1111, 8, 1'b0, 16'h0);
        mdat[0] = 32'h0004_0000;
        drive(4'b0001);
        frame(32'h0001_0000, 4'b0001, 8, 1'b0, 16'h0);
        mdat[0] = 32'hFFFD_0005;
        drive(4'b0001);
        frame(32'hFFFF_0001, 4'b0001, 8, 1'b0, 16'h0);
        chk("irq_mix_ok", 32'(bus.interrupt), 32'h0);
        drive(4'b0000);
        frame(32'h0000_0000, 4'b0000, 8, 1'b0, 16'h0);
        chk("irq_mix_underrun", 32'(bus.interrupt), 32'h1);
        cfg(16'h0012);
        chk("irq_mix_cleared", 32'(bus.interrupt), 32'h0);

        cfg(16'h0004);
        mdat[1] = 32'hCAFE_F00D;
        drive(4'b0010);
        frame(32'hCAFE_F00D, 4'b0010, 4, 1'b0, 16'h0);
        drive(4'b0001);
        frame(32'hCAFE_F00D, 4'b0000, 4, 1'b0, 16'h0);
        chk("irq_fixed_underrun", 32'(bus.interrupt), 32'h1);
        chk("rd_sticky", 32'(bus.CFG_READDATA), 32'h0014);
        cfg(16'h0014);
        chk("irq_fixed_cleared", 32'(bus.interrupt), 32'h0);

        cfg(16'h0003);
        drive(4'b1111);
        frame(32'h0000_0000, 4'b0000, 4, 1'b0, 16'h0);
        chk("rd_mute", 32'(bus.CFG_READDATA), 32'h0003);

        cfg(16'h0004);
        mdat = '{32'h0100_0010, 32'h0200_0020, 32'h0300_0030, 32'h0400_0040};
        drive(4'b1111);
        frame(32'h0200_0020, 4'b0010, 4, 1'b1, 16'h0002);
        chk("rd_mode_held", 32'(bus.CFG_READDATA), 32'h0004);
        frame(32'h0280_0028, 4'b1111, 8, 1'b0, 16'h0);
        chk("rd_mode_mix", 32'(bus.CFG_READDATA), 32'h0002);

        @(negedge clk);
        lrck = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_codec", bus.codec_stream, 32'h0);
        chk("abort_strobe", 32'(bus.frame_strobe), 32'h0);
        chk("abort_ack", 32'(bus.MIC_ACK), 32'h0);
        chk("abort_rd", 32'(bus.CFG_READDATA), 32'h0);
        @(negedge clk);
        s0 = strobes;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_strobe_level_high", 32'(strobes - s0), 32'h0);
        lrck = 1'b0;
        repeat (4) @(negedge clk);
        frame(32'h0100_0010, 4'b0001, 4, 1'b0, 16'h0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
